// File: rtl/ifetch.sv
// Instruction fetch unit: issues word reads on bus master1 and buffers the returned
// instructions with their addresses in a small prefetch FIFO for decode.
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        m1_re,
  output logic        m1_we,
  output logic        m1_load_sign,
  output logic [3:0]  m1_byte_mask,
  output logic [31:0] m1_addr,
  output logic [31:0] m1_wdata,
  input  logic [31:0] m1_rdata,
  input  logic        m0_busy,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [31:0]     pend_pc_q, pend_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     data_d [FIFO_DEPTH];
  logic [31:0]     addr_q [FIFO_DEPTH];
  logic [31:0]     addr_d [FIFO_DEPTH];

  logic room;
  logic accept;
  logic push;
  logic pop;
  logic unused_redirect_lsb;

  assign m1_we               = 1'b0;
  assign m1_load_sign        = 1'b0;
  assign m1_byte_mask        = 4'b1111;
  assign m1_wdata            = 32'h0;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A new request needs a free slot beyond the entries held and the one in flight.
  assign room = ({1'b0, count_q} + {{CntW{1'b0}}, pend_q} + (CntW+1)'(1))
                <= (CntW+1)'(FIFO_DEPTH);

  always_comb begin
    m1_re        = !rst && !redirect && room;
    accept       = m1_re && !m0_busy;
    push         = pend_q && !rst && !redirect;
    inst_valid_o = !rst && (count_q != '0);
    pop          = inst_valid_o && inst_ready && !redirect;
    m1_addr      = rst ? RESET_PC : pc_q;
    inst_o       = inst_valid_o ? data_q[rd_ptr_q] : 32'h0;
    inst_pc_o    = inst_valid_o ? addr_q[rd_ptr_q] : 32'h0;
  end

  always_comb begin
    pc_d      = pc_q;
    pend_d    = accept;
    pend_pc_d = accept ? pc_q : pend_pc_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    data_d    = data_q;
    addr_d    = addr_q;

    if (accept) begin
      pc_d = pc_q + 32'd4;
    end
    if (push) begin
      data_d[wr_ptr_q] = m1_rdata;
      addr_d[wr_ptr_q] = pend_pc_q;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Redirect flushes everything, including the word still on the bus.
    if (redirect) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      pend_d   = 1'b0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    addr_q <= addr_d;
  end

endmodule
